bcd_scan_display: RTL

Multiplexed 7-segment driver for the cascaded BCD decade counters. It snapshots a packed multi-digit BCD value on a load strobe and scans the digits onto one shared segment bus with one-hot digit enables. It supports leading-zero blanking and flags invalid BCD codes. It is the display-side consumer of the counter chain's q outputs.

---
 rtl/bcd_scan_display.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bcd_scan_display.sv
// bcd_scan_display
// Multiplexed 7-segment driver for a chain of BCD decade counters.
// A load strobe snapshots a packed BCD value into a shadow register. The
// digits of that snapshot are then scanned onto one shared segment bus, with
// one-hot digit enables, leading-zero blanking and a flag for invalid codes.
//
// Parameters:
//   DIGITS     number of BCD digits scanned; digit 0 is least significant
//   SCAN_DIV   clock cycles each digit stays selected (>= 1)
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   digits_in   packed BCD value; bits [4k+3:4k] hold digit k
//   load        capture digits_in into the shadow register on this edge
//   blank_lz    leading-zero blanking enable, used live
//   seg         {g,f,e,d,c,b,a}, active-high segments (registered)
//   an          one-hot digit enable, active-high (registered)
//   frame_done  one-cycle pulse when the scan wraps from the last digit to digit 0
//   bcd_err     high while any shadow digit is greater than 9
module bcd_scan_display #(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  bcd_err
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [DW-1:0]     shadow;
  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;

  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic [DIGITS:0]   upper_zero;
  logic [6:0]        seg_next;
  logic [DIGITS-1:0] an_next;
  logic              err_next;
  logic              slot_end;
  logic              frame_end;

  assign slot_end  = (presc == PRESC_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Select the current digit, decide blanking and encode it for the segments.
  always_comb begin
    cur_digit  = 4'd0;
    cur_blank  = 1'b0;
    an_next    = '0;
    err_next   = 1'b0;
    seg_next   = 7'h00;
    upper_zero = '0;

    // upper_zero[k]: every digit from k up to the top is zero (invalid counts as non-zero).
    upper_zero[DIGITS] = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (shadow[4*k +: 4] == 4'd0);
    end

    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_digit  = shadow[4*k +: 4];
        an_next[k] = 1'b1;
        cur_blank  = blank_lz && (k != 0) && upper_zero[k];
      end
      if (shadow[4*k +: 4] > 4'd9) begin
        err_next = 1'b1;
      end
    end

    case (cur_digit)
      4'd0:    seg_next = 7'h3F;
      4'd1:    seg_next = 7'h06;
      4'd2:    seg_next = 7'h5B;
      4'd3:    seg_next = 7'h4F;
      4'd4:    seg_next = 7'h66;
      4'd5:    seg_next = 7'h6D;
      4'd6:    seg_next = 7'h7D;
      4'd7:    seg_next = 7'h07;
      4'd8:    seg_next = 7'h7F;
      4'd9:    seg_next = 7'h6F;
      default: seg_next = 7'h40;
    endcase

    if (cur_blank) begin
      seg_next = 7'h00;
    end
  end

  // Shadow capture, scan counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow     <= '0;
      presc      <= '0;
      idx        <= '0;
      an         <= '0;
      seg        <= 7'h00;
      frame_done <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      if (load) begin
        shadow <= digits_in;
      end

      if (slot_end) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end

      an         <= an_next;
      seg        <= seg_next;
      frame_done <= frame_end;
      // Reflects the shadow as it stood after the previous edge.
      bcd_err    <= err_next;
    end
  end

endmodule
